// File: rtl/nvram_upload.sv
// ---------------------------------------------------------------------------
// nvram_upload
//
// Returns a window of game RAM to the HPS over the ioctl upload direction,
// for saving high scores / NVRAM.  While a selected upload is open the CPU is
// held through pause_req/pause_ack, bytes are fetched through a spare RAM
// read port, and an 8-bit wrap-around checksum byte follows the data.
//
// Ports
//   clk_sys       system clock (only clock)
//   reset         asynchronous, active-high reset
//   ioctl_upload  high for the whole upload transfer
//   ioctl_index   file index of the transfer
//   ioctl_rd      one-cycle read strobe from the HPS
//   ioctl_addr    byte address, valid with ioctl_rd
//   ioctl_din     read data returned to the HPS
//   ioctl_wait    HPS must not sample ioctl_din or strobe ioctl_rd while high
//   pause_req     request to halt the CPU
//   pause_ack     CPU halted, RAM quiescent
//   ram_rd        one-cycle RAM read enable
//   ram_addr      RAM read address
//   ram_q         RAM data, valid one cycle after ram_rd
//   active        a transfer selected for this block is in progress
//   done          one-cycle pulse when a transfer ends
//   dbg_state     current FSM state, for observation only
//
// Handshake: the HPS issues one ioctl_rd strobe per byte only while
// ioctl_wait is low; the byte in ioctl_din is valid from the first cycle in
// which ioctl_wait is low again after that strobe.  A strobe seen while the
// CPU pause is still pending is held and served once the pause is granted.
// ---------------------------------------------------------------------------
module nvram_upload #(
    parameter logic [7:0] INDEX  = 8'd4,
    parameter int         RAM_AW = 10,
    parameter int         BASE   = 0,
    parameter int         LEN    = 64
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic              ram_rd,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [7:0]        ram_q,
    output logic              active,
    output logic              done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAUSE   = 3'd1,
        S_READY   = 3'd2,
        S_FETCH   = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    localparam logic [RAM_AW-1:0] BASE_A = RAM_AW'(BASE);
    localparam logic [24:0]       LEN_A  = 25'(LEN);

    state_t             state, state_nxt;
    logic               sel, sel_d, sel_rise, sel_fall;
    logic               pend, pend_nxt;
    logic [24:0]        pend_addr, pend_addr_nxt;
    logic [7:0]         sum, sum_nxt;
    logic [7:0]         din_nxt;
    logic [RAM_AW-1:0]  ram_addr_nxt;
    logic               svc;
    logic [24:0]        svc_addr;

    assign sel      = ioctl_upload & (ioctl_index == INDEX);
    assign sel_rise = sel & ~sel_d;
    assign sel_fall = ~sel & sel_d;

    // A held strobe from the PAUSE state takes precedence over a fresh one.
    assign svc      = (state == S_READY) & (pend | ioctl_rd);
    assign svc_addr = pend ? pend_addr : ioctl_addr;

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // State register (all outputs are registered here as well)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            sel_d      <= 1'b0;
            pend       <= 1'b0;
            pend_addr  <= '0;
            sum        <= 8'h00;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            active     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel_d      <= sel;
            pend       <= pend_nxt;
            pend_addr  <= pend_addr_nxt;
            sum        <= sum_nxt;
            ioctl_din  <= din_nxt;
            ioctl_wait <= (state_nxt == S_PAUSE) | (state_nxt == S_FETCH) |
                          (state_nxt == S_CAPTURE);
            pause_req  <= (state_nxt != S_IDLE);
            active     <= (state_nxt != S_IDLE);
            ram_rd     <= (state_nxt == S_FETCH);
            ram_addr   <= ram_addr_nxt;
            done       <= sel_fall;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; a falling sel ends the transfer from any state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (sel_fall) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (sel_rise) state_nxt = S_PAUSE;
                S_PAUSE:   if (pause_ack) state_nxt = S_READY;
                S_READY:   if (svc && (svc_addr < LEN_A)) state_nxt = S_FETCH;
                S_FETCH:   state_nxt = S_CAPTURE;
                S_CAPTURE: state_nxt = S_READY;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        din_nxt       = ioctl_din;
        sum_nxt       = sum;
        ram_addr_nxt  = ram_addr;
        pend_nxt      = pend;
        pend_addr_nxt = pend_addr;
        if (sel_fall) begin
            // Any in-flight fetch or held strobe is dropped; ioctl_din keeps
            // the last byte served.
            pend_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_rise) begin
                        sum_nxt  = 8'h00;
                        pend_nxt = 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (ioctl_rd) begin
                        pend_nxt      = 1'b1;
                        pend_addr_nxt = ioctl_addr;
                    end
                end
                S_READY: begin
                    if (svc) begin
                        pend_nxt = 1'b0;
                        if (svc_addr < LEN_A) begin
                            ram_addr_nxt = BASE_A + RAM_AW'(svc_addr[7:0]);
                        end else if (svc_addr == LEN_A) begin
                            din_nxt = sum;
                        end else begin
                            din_nxt = 8'hFF;
                        end
                    end
                end
                S_CAPTURE: begin
                    din_nxt = ram_q;
                    sum_nxt = sum + ram_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
